// File: rtl/op_scheduler_if.sv
// op_scheduler_if: request, opcode handshake and status bundle.
// master = scheduler side, slave = requesters/datapath side.
interface op_scheduler_if;
    logic       dpp_ready_in;
    logic       nd_ready_in;
    logic       na_in;
    logic       op_ready_in;
    logic       op_done_in;
    logic [1:0] opcode_out;
    logic       op_valid_out;
    logic       busy_out;
    logic       timeout_out;
    logic       tx_forced_out;

    modport master (
        input  dpp_ready_in, nd_ready_in, na_in,
        input  op_ready_in, op_done_in,
        output opcode_out, op_valid_out, busy_out,
        output timeout_out, tx_forced_out
    );

    modport slave (
        output dpp_ready_in, nd_ready_in, na_in,
        output op_ready_in, op_done_in,
        input  opcode_out, op_valid_out, busy_out,
        input  timeout_out, tx_forced_out
    );
endinterface

// File: rtl/op_scheduler.sv
// op_scheduler: registered RX/TX opcode arbiter with issue handshake,
// completion tracking, timeout abort and optional TX starvation guard.
// Ports: clk, reset (async, active-high), bus (op_scheduler_if.master):
//   requests dpp_ready_in/nd_ready_in/na_in, handshake op_ready_in,
//   op_done_in, outputs opcode_out, op_valid_out, busy_out,
//   timeout_out, tx_forced_out.
// Build option: OPSCHED_STARVE_GUARD_EN enables the streak counter and
//   forced-TXE override; otherwise strict LOG > RXA > TXE priority.
module op_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic clk,
    input  logic reset,
    op_scheduler_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_TXE = 2'b01;
    localparam logic [1:0] OP_RXA = 2'b10;
    localparam logic [1:0] OP_LOG = 2'b11;

    // TIMEOUT=0 still needs a 1-bit counter to keep widths legal.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    if (STARVE_LIMIT < 1) begin : g_bad_starve
        $error("STARVE_LIMIT must be >= 1");
    end

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic          grant;
    logic [1:0]    grant_op;
    logic          forced;
    logic          log_req;
    logic          rxa_req;
    logic          txe_req;

    // Mutually exclusive request terms encode the fixed priority.
    assign log_req = bus.nd_ready_in & bus.na_in;
    assign rxa_req = bus.nd_ready_in & ~bus.na_in;
    assign txe_req = bus.dpp_ready_in & ~bus.nd_ready_in;

`ifdef OPSCHED_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak;

    assign forced = bus.dpp_ready_in & (streak == SMAX);
`else
    assign forced = 1'b0;
`endif

    always_comb begin
        grant    = 1'b0;
        grant_op = OP_NOP;
        if (forced) begin
            grant    = 1'b1;
            grant_op = OP_TXE;
        end else begin
            unique case (1'b1)
                log_req: begin
                    grant    = 1'b1;
                    grant_op = OP_LOG;
                end
                rxa_req: begin
                    grant    = 1'b1;
                    grant_op = OP_RXA;
                end
                txe_req: begin
                    grant    = 1'b1;
                    grant_op = OP_TXE;
                end
                default: ;
            endcase
        end
    end

    assign tcnt_nxt = (tcnt == '1) ? tcnt : tcnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            tcnt              <= '0;
            bus.opcode_out    <= OP_NOP;
            bus.op_valid_out  <= 1'b0;
            bus.busy_out      <= 1'b0;
            bus.timeout_out   <= 1'b0;
            bus.tx_forced_out <= 1'b0;
`ifdef OPSCHED_STARVE_GUARD_EN
            streak            <= '0;
`endif
        end else begin
            bus.timeout_out   <= 1'b0;
            bus.tx_forced_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        bus.opcode_out    <= grant_op;
                        bus.op_valid_out  <= 1'b1;
                        bus.busy_out      <= 1'b1;
                        bus.tx_forced_out <= forced;
                        state             <= ISSUE;
`ifdef OPSCHED_STARVE_GUARD_EN
                        if (grant_op == OP_TXE) begin
                            streak <= '0;
                        end else if (bus.dpp_ready_in) begin
                            streak <= (streak == SMAX) ? streak
                                                       : streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
`endif
                    end else begin
                        bus.opcode_out <= OP_NOP;
                    end
                end
                ISSUE: begin
                    if (bus.op_ready_in) begin
                        bus.op_valid_out <= 1'b0;
                        tcnt             <= '0;
                        state            <= BUSY;
                    end
                end
                BUSY: begin
                    // Done is checked first so it wins over a
                    // same-cycle timeout.
                    if (bus.op_done_in) begin
                        bus.opcode_out <= OP_NOP;
                        bus.busy_out   <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        tcnt <= tcnt_nxt;
                        if ((TIMEOUT != 0) && (tcnt_nxt == TMAX)) begin
                            bus.timeout_out <= 1'b1;
                            bus.opcode_out  <= OP_NOP;
                            bus.busy_out    <= 1'b0;
                            state           <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_scheduler.sv
// tb_op_scheduler: directed tests for op_scheduler
// (STARVE_LIMIT=4, TIMEOUT=5).
module tb_op_scheduler;

    logic clk;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    op_scheduler_if bus ();

    op_scheduler #(
        .STARVE_LIMIT(4),
        .TIMEOUT(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // {opcode[1:0], op_valid, busy, timeout, tx_forced}
    logic [5:0] st;
    assign st = {bus.opcode_out, bus.op_valid_out, bus.busy_out,
                 bus.timeout_out, bus.tx_forced_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dpp_ready_in = 1'b0;
        bus.nd_ready_in  = 1'b0;
        bus.na_in        = 1'b0;
        bus.op_ready_in  = 1'b0;
        bus.op_done_in   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        vectors++;
        if (st !== 6'b000000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", st, 6'b000000);
        end
        bus.dpp_ready_in = 1'b1;
        bus.nd_ready_in  = 1'b1;
        tick();
        vectors++;
        if (st !== 6'b000000) begin
            errors++;
            $display("FAIL reset_beats_grant got=%b exp=%b", st, 6'b000000);
        end
        clear_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_tx_single();
        do_reset();
        bus.dpp_ready_in = 1'b1;
        bus.op_ready_in  = 1'b1;
        tick();
        vectors++;
        if (st !== 6'b011100) begin
            errors++;
            $display("FAIL tx_issue got=%b exp=%b", st, 6'b011100);
        end
        bus.dpp_ready_in = 1'b0;
        tick();
        vectors++;
        if (st !== 6'b010100) begin
            errors++;
            $display("FAIL tx_busy got=%b exp=%b", st, 6'b010100);
        end
        bus.op_ready_in = 1'b0;
        bus.op_done_in  = 1'b1;
        tick();
        vectors++;
        if (st !== 6'b000000) begin
            errors++;
            $display("FAIL tx_done got=%b exp=%b", st, 6'b000000);
        end
        bus.op_done_in = 1'b0;
        tick();
        vectors++;
        if (st !== 6'b000000) begin
            errors++;
            $display("FAIL tx_idle got=%b exp=%b", st, 6'b000000);
        end
    endtask

    task automatic test_log_hold();
        do_reset();
        bus.nd_ready_in  = 1'b1;
        bus.na_in        = 1'b1;
        bus.dpp_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (st !== 6'b111100) begin
                errors++;
                $display("FAIL log_hold[%0d] got=%b exp=%b", i, st, 6'b111100);
            end
        end
        bus.op_ready_in = 1'b1;
        tick();
        vectors++;
        if (st !== 6'b110100) begin
            errors++;
            $display("FAIL log_accept got=%b exp=%b", st, 6'b110100);
        end
        bus.op_ready_in = 1'b0;
        bus.op_done_in  = 1'b1;
        tick();
        vectors++;
        if (st !== 6'b000000) begin
            errors++;
            $display("FAIL log_done got=%b exp=%b", st, 6'b000000);
        end
        clear_inputs();
    endtask

    task automatic test_starve_guard();
        logic [5:0] exp_issue;
        logic [5:0] exp_busy;
        do_reset();
        bus.nd_ready_in  = 1'b1;
        bus.dpp_ready_in = 1'b1;
        bus.op_ready_in  = 1'b1;
        bus.op_done_in   = 1'b1;
        for (int g = 0; g < 10; g++) begin
`ifdef OPSCHED_STARVE_GUARD_EN
            exp_issue = (g == 4) ? 6'b011101 : 6'b101100;
            exp_busy  = (g == 4) ? 6'b010100 : 6'b100100;
`else
            exp_issue = 6'b101100;
            exp_busy  = 6'b100100;
`endif
            tick();
            vectors++;
            if (st !== exp_issue) begin
                errors++;
                $display("FAIL starve_issue[%0d] got=%b exp=%b",
                         g, st, exp_issue);
            end
            tick();
            vectors++;
            if (st !== exp_busy) begin
                errors++;
                $display("FAIL starve_busy[%0d] got=%b exp=%b",
                         g, st, exp_busy);
            end
            tick();
            vectors++;
            if (st !== 6'b000000) begin
                errors++;
                $display("FAIL starve_idle[%0d] got=%b exp=%b",
                         g, st, 6'b000000);
            end
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            bus.dpp_ready_in = 1'b1;
            bus.op_ready_in  = 1'b1;
            tick();
            bus.dpp_ready_in = 1'b0;
            tick();
            vectors++;
            if (st !== 6'b010100) begin
                errors++;
                $display("FAIL to_enter[%0d] got=%b exp=%b", v, st, 6'b010100);
            end
            bus.op_ready_in = 1'b0;
            for (int c = 1; c < 5; c++) begin
                tick();
                vectors++;
                if (st !== 6'b010100) begin
                    errors++;
                    $display("FAIL to_wait[%0d,%0d] got=%b exp=%b",
                             v, c, st, 6'b010100);
                end
            end
            bus.op_done_in = (v == 1);
            tick();
            vectors++;
            if (st !== ((v == 0) ? 6'b000010 : 6'b000000)) begin
                errors++;
                $display("FAIL to_edge5[%0d] got=%b exp=%b", v, st,
                         (v == 0) ? 6'b000010 : 6'b000000);
            end
            bus.op_done_in = 1'b0;
            tick();
            vectors++;
            if (st !== 6'b000000) begin
                errors++;
                $display("FAIL to_after[%0d] got=%b exp=%b", v, st, 6'b000000);
            end
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        bus.dpp_ready_in = 1'b1;
        bus.op_ready_in  = 1'b1;
        tick();
        bus.dpp_ready_in = 1'b0;
        tick();
        bus.op_ready_in = 1'b0;
        tick();
        tick();
        vectors++;
        if (st !== 6'b010100) begin
            errors++;
            $display("FAIL rb_busy got=%b exp=%b", st, 6'b010100);
        end
        reset = 1'b1;
        #2;
        vectors++;
        if (st !== 6'b000000) begin
            errors++;
            $display("FAIL rb_async got=%b exp=%b", st, 6'b000000);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (st !== 6'b000000) begin
                errors++;
                $display("FAIL rb_after[%0d] got=%b exp=%b", c, st, 6'b000000);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_tx_single();
        test_log_hold();
        test_starve_guard();
        test_timeout();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
